// File: rtl/capture_pkg.sv
// Shared types and defaults for the ADC capture controller.
// Holds the capture FSM state enum and parameter defaults.
package capture_pkg;

  localparam int CAP_DATA_W     = 16;
  localparam int CAP_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    DONE
  } capture_state_t;

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through FIFO for packed words plus last flag.
// Ports: clk, resetn, wr_en/wr_data/full, rd_en/rd_data/empty.
module capture_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  // a full FIFO still takes a word when one leaves on the same edge
  assign do_wr = wr_en && (!full || do_rd);

  // zero while empty so the stream outputs read 0 out of reset
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/capture_ctrl.sv
// Packs ADC sample pairs into words and streams a packet over AXI4-Stream.
// Ports: start/pkt_size, adc_valid/adc_data, m_axis_*, busy/done/overflow/beats_sent.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W     = CAP_DATA_W,
  parameter int FIFO_DEPTH = CAP_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       pkt_size,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [29:0]       beats_sent
);

  localparam int FW = 2*DATA_W + 1;

  capture_state_t state, state_nx;

  logic              phase;
  logic [DATA_W-1:0] pack_lo;
  logic [29:0]       word_total;
  logic [29:0]       word_cnt;
  logic              samp;
  logic              push_try;
  logic              push_ok;
  logic              pop;
  logic              last_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic              unused_pkt_lsb;

  assign unused_pkt_lsb = ^pkt_size[1:0];

  assign samp      = (state == CAPTURE) && adc_valid;
  assign push_try  = samp && phase;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_ok   = push_try && (!fifo_full || pop);
  assign last_word = (word_cnt == word_total - 30'd1);
  assign fifo_din  = {last_word, adc_data, pack_lo};

  capture_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push_try),
    .wr_data (fifo_din),
    .full    (fifo_full),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_dout),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[FW-2:0];
  assign m_axis_tlast  = fifo_dout[FW-1];

  assign busy = (state == CAPTURE) || (state == FLUSH);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (pkt_size[31:2] == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (push_ok && last_word) state_nx = FLUSH;
      end
      FLUSH: begin
        if (pop && m_axis_tlast) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase      <= 1'b0;
      pack_lo    <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      overflow   <= 1'b0;
      beats_sent <= '0;
    end else begin
      if (state == IDLE && start) begin
        word_total <= pkt_size[31:2];
        word_cnt   <= '0;
        phase      <= 1'b0;
        overflow   <= 1'b0;
        beats_sent <= '0;
      end else begin
        if (samp) begin
          // phase flips even when the pair is dropped
          phase <= ~phase;
          if (!phase) pack_lo <= adc_data;
        end
        if (push_ok) word_cnt <= word_cnt + 30'd1;
        if (push_try && !push_ok) overflow <= 1'b1;
        if (pop && beats_sent != '1) beats_sent <= beats_sent + 30'd1;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: ramp packets, stalls, overflow, restart.
// Expected beats are hand-derived from the ramp sample index.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] pkt_size;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [29:0] beats_sent;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] bq_d[$];
  bit          bq_l[$];

  bit          stall_prev = 0;
  logic [31:0] hold_d;
  logic        hold_l;

  always #5 clk = ~clk;

  capture_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .pkt_size      (pkt_size),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .beats_sent    (beats_sent)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change #1 after posedge, so negedge sees the handshake
  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", 64'(m_axis_tdata), 64'(hold_d));
        chk("hold_last", 64'(m_axis_tlast), 64'(hold_l));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        bq_d.push_back(m_axis_tdata);
        bq_l.push_back(m_axis_tlast);
      end
    end
  end

  function automatic logic [31:0] exp_word(int p);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(2*p);
    hi = 16'(2*p + 1);
    return {hi, lo};
  endfunction

  // rdy_mode: 0 always ready, 1 ready one cycle in three,
  // 2 not ready until stall_pairs pairs have been offered
  task automatic do_pkt(input int bytes, input int adc_per,
                        input int rdy_mode, input int stall_pairs,
                        input int restart_at, input int abort_beat,
                        input int n_words, input int keep, input int skip,
                        input int exp_ovf);
    int  cyc;
    int  samp;
    bit  got_done;
    bit  aborted;
    cyc = 0;
    samp = 0;
    got_done = 0;
    aborted = 0;
    bq_d.delete();
    bq_l.delete();
    @(posedge clk); #1;
    start = 1'b1;
    pkt_size = 32'(bytes);
    @(posedge clk); #1;
    start = 1'b0;
    if (bytes >= 4) chk("busy_after_start", 64'(busy), 64'd1);
    while (cyc < 2000 && !got_done && !aborted) begin
      if (done) begin
        got_done = 1;
      end else if (abort_beat > 0 && bq_d.size() >= abort_beat) begin
        resetn = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beats", 64'(beats_sent), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        adc_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        aborted = 1;
      end else begin
        start = (cyc == restart_at);
        pkt_size = 32'd8;
        adc_valid = ((cyc % adc_per) == 0);
        adc_data = 16'(samp);
        unique case (rdy_mode)
          0: m_axis_tready = 1'b1;
          1: m_axis_tready = ((cyc % 3) == 0);
          default: m_axis_tready = (samp >= 2*stall_pairs);
        endcase
        if (adc_valid) samp++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    adc_valid = 1'b0;
    start = 1'b0;
    m_axis_tready = 1'b1;
    if (!aborted) begin
      chk("done_seen", 64'(got_done), 64'd1);
      chk("tvalid_at_done", 64'(m_axis_tvalid), 64'd0);
      chk("beat_count", 64'(bq_d.size()), 64'(n_words));
      for (int k = 0; k < bq_d.size() && k < n_words; k++) begin
        chk($sformatf("beat%0d_data", k), 64'(bq_d[k]),
            64'(exp_word(k < keep ? k : k + skip)));
        chk($sformatf("beat%0d_last", k), 64'(bq_l[k]),
            64'(k == n_words - 1));
      end
      chk("beats_sent", 64'(beats_sent), 64'(n_words));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    pkt_size = '0;
    adc_valid = 1'b0;
    adc_data = '0;
    m_axis_tready = 1'b1;
    #2;
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_beats", 64'(beats_sent), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // full-rate ramp, always ready
    do_pkt(64, 1, 0, 0, -1, 0, 16, 16, 0, 0);
    // slow ADC, stalled sink
    do_pkt(64, 4, 1, 0, -1, 0, 16, 16, 0, 0);
    // sink blocked for 12 pairs: pairs 4..11 dropped
    do_pkt(64, 1, 2, 12, -1, 0, 16, 4, 8, 1);
    // empty packet
    do_pkt(0, 1, 0, 0, -1, 0, 0, 0, 0, 0);
    // single-word packet, low bits ignored
    do_pkt(6, 1, 0, 0, -1, 0, 1, 1, 0, 0);
    // second start during capture is ignored
    do_pkt(64, 2, 0, 0, 10, 0, 16, 16, 0, 0);
    // reset once five beats are out
    do_pkt(64, 1, 0, 0, -1, 5, 16, 16, 0, 0);
    // clean packet after the reset
    do_pkt(16, 1, 0, 0, -1, 0, 4, 4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, ADC sample width; output word is 2*DATA_W.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer depth in words; SHALL be a power of 2, at least 2.
REQ-003 clk  in  1  sole clock; all logic rises on posedge clk.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins one packet capture.
REQ-006 pkt_size  in  32  packet length in bytes; bits [1:0] ignored.
REQ-007 adc_valid  in  1  one-cycle strobe marking a new sample already synchronised to clk.
REQ-008 adc_data  in  DATA_W  sample value, valid only while adc_valid=1.
REQ-009 m_axis_tdata  out  2*DATA_W  packed sample pair, {odd sample, even sample}.
REQ-010 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  AXI4-Stream master toward the S2MM DMA.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when the packet is complete.
REQ-013 overflow  out  1  sticky flag: a packed word was dropped because the FIFO was full.
REQ-014 beats_sent  out  30  count of accepted output beats in the current or last packet.

Function
REQ-015 States: IDLE, CAPTURE, FLUSH, DONE.
REQ-016 IDLE: start=1 latches word_total=pkt_size[31:2] and clears beats_sent, overflow, pair phase and word_cnt; start in any other state is ignored.
REQ-017 IDLE->DONE when start=1 and word_total=0; no beats are produced.
REQ-018 IDLE->CAPTURE when start=1 and word_total>0.
REQ-019 CAPTURE: phase 0 sample -> low half of the pack register; phase 1 sample -> high half, and the word is pushed on that same edge with last=(word_cnt==word_total-1).
REQ-020 The phase toggles on every adc_valid, including a dropped pair.
REQ-021 word_cnt increments only on a successful push, so tlast is never lost.
REQ-022 Push with FIFO full: word dropped, overflow<=1, word_cnt unchanged; capture continues.
REQ-023 CAPTURE->FLUSH on the edge that pushes the last word; adc_valid is ignored from then on.
REQ-024 FLUSH->DONE on the edge where the beat with tlast=1 is accepted (tvalid&&tready).
REQ-025 DONE lasts one cycle with done=1, busy=0, then IDLE.
REQ-026 FIFO is first-word-fall-through: a word pushed on edge N gives m_axis_tvalid=1 from cycle N+1.
REQ-027 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable; tvalid never drops without a handshake.
REQ-028 Simultaneous push and pop on a full FIFO is accepted (no overflow); on an empty FIFO the pop is impossible because tvalid=0.
REQ-029 beats_sent increments on each handshake and saturates at 2^30-1.
REQ-030 Output values after reset: tvalid=0, tlast=0, tdata=0, busy=0, done=0, overflow=0, beats_sent=0.

Reset
REQ-031 resetn low forces the state to IDLE, empties the FIFO, sets phase=0, and clears all counters and REQ-030 outputs at once, with no clock needed.
REQ-032 Reset mid-packet discards the partial packet; no tlast is emitted for it.
REQ-033 Deassertion of resetn is assumed synchronised externally to clk.

Structure
REQ-034 Package capture_pkg holds the state enum capture_state_t and the DATA_W and FIFO_DEPTH defaults.
REQ-035 Sub-module capture_fifo: a synchronous FWFT FIFO of width 2*DATA_W+1 (data plus last), with full/empty flags and the same clk/resetn.

Verification
REQ-036 pkt_size=64, tready=1, ramp samples 0..31 -> 16 beats 0x00010000, 0x00030002, ... 0x001F001E; tlast only on beat 16; done 1 cycle after; beats_sent=16.
REQ-037 pkt_size=64, tready toggled 1-of-3 cycles, adc_valid every 4th cycle -> identical data, stable tdata during stalls, overflow=0.
REQ-038 pkt_size=64, tready=0 for the first 12 sample pairs -> first 4 words kept, overflow=1; remaining words still finish with tlast and done.
REQ-039 pkt_size=0 -> done pulse 1 cycle after start, no tvalid; pkt_size=6 -> exactly 1 beat with tlast=1.
REQ-040 start pulsed again during CAPTURE -> ignored and word_total unchanged; resetn pulsed low at beat 5 -> tvalid=0 and busy=0 at once, and the next start runs a clean packet.
